// File: rtl/fxp_acc_pipe.sv
// Streaming signed fixed-point accumulator: sums an in_last-delimited burst of products,
// saturates into the output format and holds the result in a single-entry valid/ready register.
module fxp_acc_pipe #(
    parameter int WII   = 8,
    parameter int WIF   = 32,
    parameter int WOI   = 8,
    parameter int WOF   = 32,
    parameter int GUARD = 8,
    parameter int ROUND = 1,
    parameter int CNT_W = GUARD + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WII+WIF-1:0]   in_data,
    input  logic                 in_overflow,
    input  logic                 in_valid,
    input  logic                 in_last,
    output logic                 in_ready,
    output logic [WOI+WOF-1:0]   out_data,
    output logic                 out_overflow,
    output logic [CNT_W-1:0]     out_count,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int IW = WII + WIF;
    localparam int OW = WOI + WOF;
    localparam int AW = WII + GUARD + WIF;
    localparam int D  = WIF - WOF;
    localparam int SW = AW + 1 - D;

    // Half of the output LSB, added before the fractional bits are dropped
    localparam logic [AW:0] RND_K = (ROUND != 0 && D > 0) ?
                                    ((AW+1)'(1) << ((D > 0) ? D - 1 : 0)) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(1) << GUARD;
    localparam logic [OW-1:0] OUT_MAX = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] OUT_MIN = {1'b1, {(OW-1){1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [AW-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic              sticky_reg, sticky_next;

    logic [OW-1:0]     out_data_reg, out_data_next;
    logic              out_overflow_reg, out_overflow_next;
    logic [CNT_W-1:0]  out_count_reg, out_count_next;
    logic              out_valid_reg, out_valid_next;

    logic              accept;
    logic signed [AW-1:0] term_ext;
    logic signed [AW-1:0] acc_base;
    logic signed [AW-1:0] sum;
    logic [CNT_W-1:0]  cnt_base;
    logic [CNT_W-1:0]  cnt_inc;
    logic              cnt_full;
    logic              sticky_base;

    logic signed [AW:0]   sum_rnd;
    logic signed [SW-1:0] shv;
    logic                 hi_ok;
    logic [OW-1:0]        conv;
    logic                 sat;

    // Input is only stalled while a finished result is blocked downstream
    assign in_ready = !(out_valid_reg && !out_ready);
    assign accept   = in_valid && in_ready;

    assign term_ext    = AW'(signed'(in_data));
    assign acc_base    = (state_reg == ACC) ? signed'(acc_reg) : '0;
    assign cnt_base    = (state_reg == ACC) ? cnt_reg : '0;
    assign sticky_base = (state_reg == ACC) ? sticky_reg : 1'b0;
    assign sum         = acc_base + term_ext;

    // Counter saturates at 2^GUARD; a term beyond that still adds but flags overflow
    assign cnt_full = (cnt_base == CNT_MAX);
    assign cnt_inc  = cnt_full ? cnt_base : cnt_base + CNT_W'(1);

    // One extra MSB so the rounding carry cannot wrap before the clamp sees it
    assign sum_rnd = (AW+1)'(sum) + signed'(RND_K);
    assign shv     = sum_rnd[AW:D];
    assign hi_ok   = (&shv[SW-1:OW-1]) || !(|shv[SW-1:OW-1]);
    assign conv    = hi_ok ? shv[OW-1:0] : (shv[SW-1] ? OUT_MIN : OUT_MAX);
    assign sat     = !hi_ok;

    always_comb begin
        state_next        = state_reg;
        acc_next          = acc_reg;
        cnt_next          = cnt_reg;
        sticky_next       = sticky_reg;
        out_data_next     = out_data_reg;
        out_overflow_next = out_overflow_reg;
        out_count_next    = out_count_reg;
        out_valid_next    = out_valid_reg;

        if (out_valid_reg && out_ready) begin
            out_valid_next = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                state_next        = IDLE;
                acc_next          = '0;
                cnt_next          = '0;
                sticky_next       = 1'b0;
                out_data_next     = conv;
                out_overflow_next = sticky_base | in_overflow | sat | cnt_full;
                out_count_next    = cnt_inc;
                out_valid_next    = 1'b1;
            end else begin
                state_next  = ACC;
                acc_next    = sum;
                cnt_next    = cnt_inc;
                sticky_next = sticky_base | in_overflow | cnt_full;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= IDLE;
            acc_reg          <= '0;
            cnt_reg          <= '0;
            sticky_reg       <= 1'b0;
            out_data_reg     <= '0;
            out_overflow_reg <= 1'b0;
            out_count_reg    <= '0;
            out_valid_reg    <= 1'b0;
        end else begin
            state_reg        <= state_next;
            acc_reg          <= acc_next;
            cnt_reg          <= cnt_next;
            sticky_reg       <= sticky_next;
            out_data_reg     <= out_data_next;
            out_overflow_reg <= out_overflow_next;
            out_count_reg    <= out_count_next;
            out_valid_reg    <= out_valid_next;
        end
    end

    assign out_data     = out_data_reg;
    assign out_overflow = out_overflow_reg;
    assign out_count    = out_count_reg;
    assign out_valid    = out_valid_reg;

endmodule
